// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared encodings for the fetch front end: NPC operations, fetch FSM
// states and the reset fetch address.
package pc_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  // NPC operation select; the execute stage drives the same encodings.
  typedef enum logic [1:0] {
    NPC_PLUS4    = 2'd0,
    NPC_BRANCH   = 2'd1,
    NPC_JUMP_IMM = 2'd2,
    NPC_JUMP_REG = 2'd3
  } npc_op_e;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    FETCH_S = 2'd0,
    WAIT_S  = 2'd1,
    FULL_S  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the shared NPC unit, issues
// single-outstanding instruction memory requests and buffers one fetched
// word for decode. A redirect kills any in-flight or buffered fetch.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // redirect from execute
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_op,
  input  logic [31:0] redirect_pc,
  input  logic [25:0] redirect_imm,
  input  logic [31:0] redirect_addr,
  // NPC unit operands and result
  output logic [31:0] npc_pc,
  output logic [1:0]  npc_op,
  output logic [25:0] npc_imm,
  output logic [31:0] npc_addr,
  input  logic [31:0] npc_in,
  // decode side
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  fetch_state_e state;
  logic [31:0]  pc_q;
  logic [31:0]  req_pc;
  logic         kill;

  // NPC computes PC+4 during sequential fetch, the redirect target otherwise.
  assign npc_pc   = redirect_valid ? redirect_pc   : pc_q;
  assign npc_op   = redirect_valid ? redirect_op   : NPC_PLUS4;
  assign npc_imm  = redirect_valid ? redirect_imm  : 26'd0;
  assign npc_addr = redirect_valid ? redirect_addr : 32'd0;

  // A redirect suppresses the request so the stale PC is never granted.
  assign imem_req  = (state == FETCH_S) && !redirect_valid;
  assign imem_addr = pc_q;

  // Fetch FSM, PC register and one-entry output buffer.
  // NOTE: the buffer word and its PC are reset too, so decode never sees X
  // on inst/inst_pc even though inst_valid qualifies them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= FETCH_S;
      pc_q       <= RESET_PC;
      req_pc     <= 32'd0;
      kill       <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
      inst_valid <= 1'b0;
    end else if (redirect_valid) begin
      // NOTE: every state update here is non-blocking so all registers see
      // the pre-edge values of each other, exactly like the hardware.
      pc_q <= npc_in;
      unique case (state)
        FETCH_S: state <= FETCH_S;
        WAIT_S: begin
          if (imem_rvalid) begin
            kill  <= 1'b0;
            state <= FETCH_S;
          end else begin
            kill  <= 1'b1;
            state <= WAIT_S;
          end
        end
        FULL_S: begin
          inst_valid <= 1'b0;
          state      <= FETCH_S;
        end
        default: state <= FETCH_S;
      endcase
    end else begin
      unique case (state)
        FETCH_S: begin
          if (imem_gnt) begin
            req_pc <= pc_q;
            pc_q   <= npc_in;
            state  <= WAIT_S;
          end
        end
        WAIT_S: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= FETCH_S;
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= req_pc;
              inst_valid <= 1'b1;
              state      <= FULL_S;
            end
          end
        end
        FULL_S: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= FETCH_S;
          end
        end
        default: state <= FETCH_S;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl. The bench plays the NPC unit and
// the instruction memory; a stream-level model tracks which address must be
// requested next and which PC decode must receive next.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_op = 2'd0;
  logic [31:0] redirect_pc = 32'd0;
  logic [25:0] redirect_imm = 26'd0;
  logic [31:0] redirect_addr = 32'd0;
  logic [31:0] npc_pc;
  logic [1:0]  npc_op;
  logic [25:0] npc_imm;
  logic [31:0] npc_addr;
  logic [31:0] npc_in;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  pc_fetch_ctrl dut (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_op(redirect_op),
    .redirect_pc(redirect_pc), .redirect_imm(redirect_imm),
    .redirect_addr(redirect_addr),
    .npc_pc(npc_pc), .npc_op(npc_op), .npc_imm(npc_imm), .npc_addr(npc_addr),
    .npc_in(npc_in),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  // Next-PC rules of the NPC unit.
  function automatic logic [31:0] npc_ref(logic [1:0] op, logic [31:0] pc,
                                          logic [25:0] imm, logic [31:0] addr);
    logic [31:0] off;
    off = {{14{imm[15]}}, imm[15:0], 2'b00};
    case (op)
      2'd0:    return pc + 32'd4;
      2'd1:    return pc + 32'd4 + off;
      2'd2:    return {pc[31:28], imm, 2'b00};
      default: return addr;
    endcase
  endfunction

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_5A5A;
  endfunction

  always_comb npc_in = npc_ref(npc_op, npc_pc, npc_imm, npc_addr);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stream model and memory responder state.
  logic [31:0] issue_exp, next_exp;
  int          n_acc, n_grant;
  bit          pending;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          gnt_mode;   // 0 never, 1 always, 2 random
  int          dly_min, dly_max;
  bit          hold_prev, wait_prev;
  logic [31:0] hold_inst, hold_pc, wait_addr;

  task automatic model_reset();
    issue_exp = RESET_PC;
    next_exp  = RESET_PC;
    hold_prev = 1'b0;
    wait_prev = 1'b0;
  endtask

  // One clock cycle: settle, check against the model, clock, drive memory.
  task automatic cycle();
    bit granted;
    logic [31:0] t;
    #1;
    if (hold_prev) begin
      check("hold_valid", {31'd0, inst_valid}, 32'd1);
      check("hold_inst", inst, hold_inst);
      check("hold_pc", inst_pc, hold_pc);
    end
    if (wait_prev) check("req_addr_stable", imem_addr, wait_addr);
    if (redirect_valid) check("req_on_redirect", {31'd0, imem_req}, 32'd0);
    if (inst_valid) check("req_while_full", {31'd0, imem_req}, 32'd0);
    granted = imem_req && imem_gnt;
    if (granted) begin
      check("grant_addr", imem_addr, issue_exp);
      issue_exp = issue_exp + 32'd4;
      pending   = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = $urandom_range(dly_max, dly_min);
      n_grant++;
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      check("accept_pc", inst_pc, next_exp);
      check("accept_inst", inst, mem_word(next_exp));
      next_exp = next_exp + 32'd4;
      n_acc++;
    end
    if (redirect_valid) begin
      t = npc_ref(redirect_op, redirect_pc, redirect_imm, redirect_addr);
      issue_exp = t;
      next_exp  = t;
    end
    hold_prev = inst_valid && !inst_ready && !redirect_valid;
    hold_inst = inst;
    hold_pc   = inst_pc;
    wait_prev = imem_req && !imem_gnt;
    wait_addr = imem_addr;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = $urandom;
    if (pending) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pending     = 1'b0;
      end
    end
    case (gnt_mode)
      0:       imem_gnt = 1'b0;
      1:       imem_gnt = 1'b1;
      default: imem_gnt = ($urandom_range(0, 1) == 1);
    endcase
    #1;
  endtask

  task automatic do_redirect(logic [1:0] op, logic [31:0] pc, logic [25:0] imm,
                             logic [31:0] addr);
    redirect_valid = 1'b1;
    redirect_op    = op;
    redirect_pc    = pc;
    redirect_imm   = imm;
    redirect_addr  = addr;
    cycle();
  endtask

  task automatic wait_full();
    int k = 0;
    while (!inst_valid && k < 20) begin cycle(); k++; end
    check("reach_full", {31'd0, inst_valid}, 32'd1);
  endtask

  // Returns after the grant cycle, i.e. with the DUT waiting for rvalid.
  task automatic wait_grant();
    int k = 0;
    while (!(imem_req && imem_gnt) && k < 20) begin cycle(); k++; end
    check("reach_grant", {31'd0, imem_req && imem_gnt}, 32'd1);
    cycle();
  endtask

  initial begin
    int a0, g0;
    logic [31:0] cap_inst, cap_pc;
    pending = 1'b0; pend_cnt = 0; pend_addr = 32'd0;
    n_acc = 0; n_grant = 0;
    gnt_mode = 1; dly_min = 1; dly_max = 1;
    model_reset();

    // Reset state.
    #12;
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_npc_op", {30'd0, npc_op}, 32'd0);
    check("rst_npc_pc", npc_pc, RESET_PC);
    @(posedge clk); #1;
    rstn = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;
    #1;

    // Zero-wait memory, ready high: one instruction every three cycles.
    a0 = n_acc; g0 = n_grant;
    for (int i = 0; i < 9; i++) cycle();
    check("tput_accepts", n_acc - a0, 3);
    check("tput_grants", n_grant - g0, 3);

    // BRANCH redirect while FULL drops the buffer.
    inst_ready = 1'b0;
    wait_full();
    do_redirect(2'd1, 32'h0000_3010, 26'h0003, 32'd0);
    check("br_valid_drop", {31'd0, inst_valid}, 32'd0);
    check("br_req", {31'd0, imem_req}, 32'd1);
    check("br_addr", imem_addr, 32'h0000_3020);
    inst_ready = 1'b1;

    // JUMP_REG redirect while WAIT; late rvalid is discarded.
    dly_min = 3; dly_max = 3;
    wait_grant();
    do_redirect(2'd3, 32'h0000_3020, 26'd0, 32'h0000_4000);
    check("jr_valid0", {31'd0, inst_valid}, 32'd0);
    cycle();
    check("jr_valid1", {31'd0, inst_valid}, 32'd0);
    check("jr_rvalid_seen", {31'd0, imem_rvalid}, 32'd1);
    cycle();
    check("jr_valid2", {31'd0, inst_valid}, 32'd0);
    check("jr_req", {31'd0, imem_req}, 32'd1);
    check("jr_addr", imem_addr, 32'h0000_4000);

    // JUMP_IMM redirect in the same cycle as rvalid.
    dly_min = 1; dly_max = 1;
    wait_grant();
    check("ji_rvalid_now", {31'd0, imem_rvalid}, 32'd1);
    do_redirect(2'd2, 32'h0000_3000, 26'h0001000, 32'd0);
    check("ji_valid", {31'd0, inst_valid}, 32'd0);
    check("ji_req", {31'd0, imem_req}, 32'd1);
    check("ji_addr", imem_addr, 32'h0000_4000);

    // Decode stalls for five cycles: buffer held, no new request.
    inst_ready = 1'b0;
    wait_full();
    cap_inst = inst; cap_pc = inst_pc;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_inst", inst, cap_inst);
      check("stall_pc", inst_pc, cap_pc);
    end
    inst_ready = 1'b1;
    cycle();

    // Reset pulse while WAIT; the stale response arrives after release.
    dly_min = 4; dly_max = 4;
    wait_grant();
    gnt_mode = 0; imem_gnt = 1'b0;
    rstn = 1'b0;
    #1;
    check("arst_addr", imem_addr, RESET_PC);
    check("arst_valid", {31'd0, inst_valid}, 32'd0);
    model_reset();
    cycle();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stale_valid", {31'd0, inst_valid}, 32'd0);
    end
    check("stale_req", {31'd0, imem_req}, 32'd1);
    check("stale_addr", imem_addr, RESET_PC);

    // Randomised traffic: grant stalls, response latency, decode
    // back-pressure and redirects of every kind at arbitrary moments.
    gnt_mode = 2; dly_min = 1; dly_max = 3;
    a0 = n_acc;
    for (int i = 0; i < 3000; i++) begin
      inst_ready = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 7)
        do_redirect(2'($urandom_range(0, 3)), {$urandom, 2'b00} & 32'hFFFF_FFFC,
                    26'($urandom), {$urandom} & 32'hFFFF_FFFC);
      else
        cycle();
    end
    check("rand_progress", {31'd0, (n_acc - a0) > 100}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
